iterative_muldiv_unit: RTL and testbench

- Multi-cycle, parametrised integer multiply/divide unit for the RV32M path (M-extension: multiply, divide and remainder instructions).
- Replaces the single-cycle combinational multiply/divide sub-ALU with a radix-2 shift-add multiplier and a restoring divider.
- Uses the same 5-bit `operation` encoding that `alu_op_selection` already produces.
- Sits beside the ALU in the execute stage. The core stalls on `busy` and takes `result` when `done` pulses.

---
 rtl/iterative_muldiv_unit_if.sv | 57 +++++
 rtl/iterative_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_iterative_muldiv_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/iterative_muldiv_unit_if.sv
// iterative_muldiv_unit_if
//
// Purpose:
//   Groups the request/response signals of iterative_muldiv_unit into one
//   bundle. The execute stage drives it through the master modport and the
//   unit receives it through the slave modport.
//
// Parameters:
//   XLEN       operand and result width (must match the unit's XLEN)
//
// Signals:
//   start      request pulse, sampled by the unit only while idle
//   kill       pipeline flush, aborts an operation in flight
//   operation  5-bit M-extension op code
//   in1        multiplicand / dividend (rs1)
//   in2        multiplier / divisor (rs2)
//   busy       operation in progress
//   done       one-cycle pulse, result valid in that cycle
//   result     registered result
//   op_err     registered flag, set when the accepted op code is unsupported
interface iterative_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [4:0]      operation;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            op_err;

    modport master (
        output start,
        output kill,
        output operation,
        output in1,
        output in2,
        input  busy,
        input  done,
        input  result,
        input  op_err
    );

    modport slave (
        input  start,
        input  kill,
        input  operation,
        input  in1,
        input  in2,
        output busy,
        output done,
        output result,
        output op_err
    );
endinterface

// File: rtl/iterative_muldiv_unit.sv
// iterative_muldiv_unit
//
// Purpose:
//   Multi-cycle RV32M multiply/divide/remainder unit. A radix-2 shift-add
//   multiplier and a restoring divider share one 2*XLEN-bit accumulator and
//   retire one bit per cycle. Signed operands are converted to magnitudes
//   on accept and the sign is restored in a final fix-up cycle.
//
// Parameters:
//   XLEN       operand and result width, must be >= 4
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   bus        iterative_muldiv_unit_if slave modport
//                (start, kill, operation, in1, in2 in;
//                 busy, done, result, op_err out)
//
// Configuration:
//   MULDIV_FAST_ZERO_EN  when defined, an accepted op with in2 == 0, or a
//                        multiply with in1 == 0, skips the iterative phase
//                        and finishes in two cycles. When undefined every
//                        supported op takes the full XLEN+2 cycle latency.
module iterative_muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic                    clk,
    input logic                    reset,
    iterative_muldiv_unit_if.slave bus
);

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b11000;
    localparam logic [4:0] OP_MULHU  = 5'b11001;
    localparam logic [4:0] OP_MULHSU = 5'b11010;
    localparam logic [4:0] OP_DIV    = 5'b10011;
    localparam logic [4:0] OP_DIVU   = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10101;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic op_supported(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU,
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_mul(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic op_signed_a(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

    function automatic logic op_signed_b(input logic [4:0] op);
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [4:0]        op_q;
    logic              sign_a;
    logic              sign_b;
    logic              b_zero;
    logic              op_err_q;
    logic [XLEN-1:0]   result_q;

    // Multiply: the multiplicand. Divide: the divisor. The other operand
    // lives in the low half of acc and is consumed one bit per cycle.
    logic [XLEN-1:0]   addend;
    logic [2*XLEN-1:0] acc;

    logic              accept;
    logic              in_supported;
    logic              in_is_mul;
    logic              in_sign_a;
    logic              in_sign_b;
    logic [XLEN-1:0]   in_a_abs;
    logic [XLEN-1:0]   in_b_abs;
    logic              fast_zero;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] acc_step;

    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic [XLEN-1:0]   fix_result;

    // kill in IDLE suppresses the start of that same cycle.
    assign accept = (state == IDLE) && bus.start && !bus.kill;

    assign in_supported = op_supported(bus.operation);
    assign in_is_mul    = op_is_mul(bus.operation);
    assign in_sign_a    = op_signed_a(bus.operation) & bus.in1[XLEN-1];
    assign in_sign_b    = op_signed_b(bus.operation) & bus.in2[XLEN-1];
    assign in_a_abs     = in_sign_a ? -bus.in1 : bus.in1;
    assign in_b_abs     = in_sign_b ? -bus.in2 : bus.in2;

`ifdef MULDIV_FAST_ZERO_EN
    assign fast_zero = (bus.in2 == '0) || (in_is_mul && (bus.in1 == '0));
`else
    assign fast_zero = 1'b0;
`endif

    // One iteration of either algorithm. The multiplier adds into the upper
    // half and shifts right; the divider shifts left and trial-subtracts.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, addend};
        acc_step  = acc;
        if (op_is_mul(op_q)) begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end else if (div_diff[XLEN]) begin
            acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and half selection. Dividing the most-negative value
    // by -1 needs no special case: the magnitude quotient is 2^(XLEN-1),
    // which already reads as the most-negative value with remainder 0.
    // Divide by zero leaves the dividend magnitude as remainder, so only
    // the quotient has to be forced to all ones.
    always_comb begin
        product    = (sign_a ^ sign_b) ? -acc : acc;
        quotient   = acc[XLEN-1:0];
        remainder  = acc[2*XLEN-1:XLEN];
        fix_result = '0;
        if (!op_err_q) begin
            case (op_q)
                OP_MUL:                       fix_result = product[XLEN-1:0];
                OP_MULH, OP_MULHU, OP_MULHSU: fix_result = product[2*XLEN-1:XLEN];
                OP_DIV, OP_DIVU: begin
                    if (b_zero) begin
                        fix_result = '1;
                    end else begin
                        fix_result = (sign_a ^ sign_b) ? -quotient : quotient;
                    end
                end
                OP_REM, OP_REMU:              fix_result = sign_a ? -remainder : remainder;
                default:                      fix_result = '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (!in_supported || fast_zero) ? FIX : CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (bus.kill) begin
                    state_next = IDLE;
                end else if (count == LAST_ITER) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                bus.busy   = 1'b1;
                state_next = bus.kill ? IDLE : DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            b_zero   <= 1'b0;
            op_err_q <= 1'b0;
            result_q <= '0;
            addend   <= '0;
            acc      <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= bus.operation;
                        sign_a   <= in_sign_a;
                        sign_b   <= in_sign_b;
                        b_zero   <= (bus.in2 == '0);
                        op_err_q <= !in_supported;
                        count    <= '0;
                        // A skipped multiply has a zero operand, so the
                        // product is zero. A skipped divide is a divide by
                        // zero: all-ones quotient, dividend as remainder.
                        if (in_is_mul) begin
                            addend <= in_a_abs;
                            acc    <= fast_zero ? '0 : {{XLEN{1'b0}}, in_b_abs};
                        end else begin
                            addend <= in_b_abs;
                            acc    <= fast_zero ? {in_a_abs, {XLEN{1'b1}}}
                                                : {{XLEN{1'b0}}, in_a_abs};
                        end
                    end
                end
                CALC: begin
                    if (!bus.kill) begin
                        acc   <= acc_step;
                        count <= count + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (!bus.kill) begin
                        result_q <= fix_result;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.op_err = op_err_q;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// tb_iterative_muldiv_unit
//
// Purpose:
//   Directed self-checking bench for iterative_muldiv_unit at XLEN = 32.
//   Each vector carries a hand-computed result, error flag and done cycle.
module tb_iterative_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b11000;
    localparam logic [4:0] OP_MULHU  = 5'b11001;
    localparam logic [4:0] OP_MULHSU = 5'b11010;
    localparam logic [4:0] OP_DIV    = 5'b10011;
    localparam logic [4:0] OP_DIVU   = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10101;
    localparam logic [4:0] OP_REMU   = 5'b10111;
    localparam logic [4:0] OP_BAD    = 5'b10110;

    localparam int FULL_LAT = 34;
`ifdef MULDIV_FAST_ZERO_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 34;
`endif

    logic clk;
    logic reset;
    int   checks_total;
    int   checks_passed;

    iterative_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    iterative_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one op from an idle unit (called #1 after a rising edge) and
    // checks busy in cycle 1, the done cycle, result and op_err.
    task automatic applyStimulus(input string tag, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_result, input logic exp_err,
                                 input int exp_cycle);
        int cyc;
        bit seen;
        bus.start     = 1'b1;
        bus.operation = op;
        bus.in1       = a;
        bus.in2       = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        checkOutput({tag, ".busy_c1"}, 64'(bus.busy), 64'd1);
        while (!seen && cyc <= 60) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        checkOutput({tag, ".done_cycle"}, seen ? 64'(cyc) : 64'd0, 64'(exp_cycle));
        checkOutput({tag, ".result"}, 64'(bus.result), 64'(exp_result));
        checkOutput({tag, ".op_err"}, 64'(bus.op_err), 64'(exp_err));
        checkOutput({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, ".done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int done_count;
        checks_total  = 0;
        checks_passed = 0;
        bus.start     = 1'b0;
        bus.kill      = 1'b0;
        bus.operation = '0;
        bus.in1       = '0;
        bus.in2       = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        checkOutput("reset.busy", 64'(bus.busy), 64'd0);
        checkOutput("reset.done", 64'(bus.done), 64'd0);
        checkOutput("reset.result", 64'(bus.result), 64'd0);
        checkOutput("reset.op_err", 64'(bus.op_err), 64'd0);

        applyStimulus("mulh_m1x2",   OP_MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, FULL_LAT);
        applyStimulus("mulhu_m1x2",  OP_MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, FULL_LAT);
        applyStimulus("mulhsu",      OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, FULL_LAT);
        applyStimulus("mul_7xm3",    OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, FULL_LAT);
        applyStimulus("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, FULL_LAT);
        applyStimulus("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, FULL_LAT);
        applyStimulus("div_m7d2",    OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, FULL_LAT);
        applyStimulus("rem_m7d2",    OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, FULL_LAT);
        applyStimulus("divu_100d7",  OP_DIVU,   32'd100,       32'd7,         32'd14,        1'b0, FULL_LAT);
        applyStimulus("divu_by0",    OP_DIVU,   32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, ZERO_LAT);
        applyStimulus("remu_by0",    OP_REMU,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, ZERO_LAT);
        applyStimulus("div_m5by0",   OP_DIV,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, ZERO_LAT);
        applyStimulus("rem_m5by0",   OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0, ZERO_LAT);
        applyStimulus("mul_0x5",     OP_MUL,    32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, ZERO_LAT);
        applyStimulus("bad_op",      OP_BAD,    32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 1'b1, 2);
        applyStimulus("remu_100d7",  OP_REMU,   32'd100,       32'd7,         32'd2,         1'b0, FULL_LAT);

        // kill while idle must block the start seen in the same cycle
        bus.start     = 1'b1;
        bus.kill      = 1'b1;
        bus.operation = OP_MUL;
        bus.in1       = 32'd3;
        bus.in2       = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        checkOutput("idle_kill.busy", 64'(bus.busy), 64'd0);

        // rem -7 % 2 killed in cycle 10: no done, result keeps 2
        bus.start     = 1'b1;
        bus.operation = OP_REM;
        bus.in1       = 32'hFFFF_FFF9;
        bus.in2       = 32'h0000_0002;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("kill.busy_c10", 64'(bus.busy), 64'd1);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        checkOutput("kill.busy_c11", 64'(bus.busy), 64'd0);
        checkOutput("kill.result", 64'(bus.result), 64'd2);
        done_count = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) done_count++;
            @(posedge clk);
            #1;
        end
        checkOutput("kill.no_done", 64'(done_count), 64'd0);
        checkOutput("kill.result_hold", 64'(bus.result), 64'd2);

        // reset in cycle 15 of a mul clears every output in cycle 16
        bus.start     = 1'b1;
        bus.operation = OP_MUL;
        bus.in1       = 32'd11;
        bus.in2       = 32'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_mid.busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_mid.done", 64'(bus.done), 64'd0);
        checkOutput("rst_mid.result", 64'(bus.result), 64'd0);
        checkOutput("rst_mid.op_err", 64'(bus.op_err), 64'd0);

        applyStimulus("mul_6x7_after_rst", OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, FULL_LAT);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
